// File: rtl/axil_decoder_addr_wr.sv
// Write-address decoder for the AXI-Lite interconnect: latches a one-hot slave
// select on AWVALID, holds it through AW/W/B, and answers unmapped writes with DECERR.
module axil_decoder_addr_wr #(
   parameter int                        NUMBER_SLAVE    = 4,
   parameter int                        AXI_ADDR_WIDTH  = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] = '{default: '0},
   parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  [NUMBER_SLAVE] = '{default: 1}
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0] addr,
   output logic [NUMBER_SLAVE-1:0]   slv_valid,
   output logic                      slv_invalid,
   input  logic                      m_axil_awvalid,
   input  logic                      m_axil_awready,
   input  logic                      m_axil_wvalid,
   input  logic                      m_axil_wready,
   input  logic                      m_axil_bvalid,
   input  logic                      m_axil_bready,
   output logic                      err_awready,
   output logic                      err_wready,
   output logic                      err_bvalid,
   output logic [1:0]                err_bresp
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [NUMBER_SLAVE-1:0] slv_valid_nxt;
   logic                    slv_invalid_nxt;
   logic                    aw_done;
   logic                    aw_done_nxt;
   logic                    w_done;
   logic                    w_done_nxt;

   logic [NUMBER_SLAVE-1:0] hit;
   logic                    miss;
   logic                    aw_hs;
   logic                    w_hs;
   logic                    b_hs;

   // Window end is computed one bit wider so a window ending at 2^W does not wrap.
   // Scanning from the top index down lets the lowest matching index win.
   always_comb begin
      hit = '0;
      for (int i = NUMBER_SLAVE - 1; i >= 0; i--) begin
         if (({1'b0, addr} >= {1'b0, AXI_ADDR_OFFSET[i]}) &&
             ({1'b0, addr} <  ({1'b0, AXI_ADDR_OFFSET[i]} + {1'b0, AXI_ADDR_RANGE[i]}))) begin
            hit    = '0;
            hit[i] = 1'b1;
         end
      end
   end

   assign miss = ~|hit;

   assign err_awready = (state == DATA) && slv_invalid && !aw_done;
   assign err_wready  = (state == DATA) && slv_invalid && !w_done;
   assign err_bvalid  = (state == RESP) && slv_invalid;
   assign err_bresp   = 2'b11;

   assign aw_hs = m_axil_awvalid && (slv_invalid ? err_awready : m_axil_awready);
   assign w_hs  = m_axil_wvalid  && (slv_invalid ? err_wready  : m_axil_wready);
   assign b_hs  = (slv_invalid ? err_bvalid : m_axil_bvalid) && m_axil_bready;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, regardless of the order blocks are evaluated.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state       <= IDLE;
         slv_valid   <= '0;
         slv_invalid <= 1'b0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
      end else begin
         state       <= state_nxt;
         slv_valid   <= slv_valid_nxt;
         slv_invalid <= slv_invalid_nxt;
         aw_done     <= aw_done_nxt;
         w_done      <= w_done_nxt;
      end
   end

   // NOTE: every output of this block is given a hold value first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt       = state;
      slv_valid_nxt   = slv_valid;
      slv_invalid_nxt = slv_invalid;
      aw_done_nxt     = aw_done;
      w_done_nxt      = w_done;

      case (state)
         IDLE: begin
            if (m_axil_awvalid) begin
               slv_valid_nxt   = hit;
               slv_invalid_nxt = miss;
               state_nxt       = DATA;
            end
         end
         DATA: begin
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               state_nxt   = RESP;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
            end else begin
               aw_done_nxt = aw_done || aw_hs;
               w_done_nxt  = w_done || w_hs;
            end
         end
         RESP: begin
            if (b_hs) begin
               state_nxt       = IDLE;
               slv_valid_nxt   = '0;
               slv_invalid_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt       = IDLE;
            slv_valid_nxt   = '0;
            slv_invalid_nxt = 1'b0;
            aw_done_nxt     = 1'b0;
            w_done_nxt      = 1'b0;
         end
      endcase
   end

endmodule
